// File: rtl/junction_pkg.sv
// Package for the junction phase scheduler.
// Holds the phase encoding, per-road lamp codes, road indices and small
// helpers for round-robin stepping and lamp generation.
package junction_pkg;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Lamp encoding {red, yellow, green}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [1:0] ROAD_A = 2'd0;
  localparam logic [1:0] ROAD_B = 2'd1;
  localparam logic [1:0] ROAD_C = 2'd2;

  // Next road in A -> B -> C -> A order
  function automatic logic [1:0] road_inc(input logic [1:0] r);
    return (r >= ROAD_C) ? ROAD_A : r + 2'd1;
  endfunction

  // Lamp shown by 'road' given the phase and the road owning it
  function automatic logic [2:0] lamp_of(input phase_e ph, input logic [1:0] act,
                                         input logic [1:0] road);
    logic [2:0] l;
    l = LAMP_RED;
    if (act == road) begin
      if (ph == PH_GREEN)       l = LAMP_GREEN;
      else if (ph == PH_YELLOW) l = LAMP_YELLOW;
    end
    return l;
  endfunction

endpackage

// File: rtl/junction_phase_scheduler_phase_timer.sv
// phase_timer: saturating phase timer.
// Ports:
//   clk      - clock, rising edge
//   clear    - synchronous clear (takes priority over enable)
//   enable   - count enable; the counter holds at all-ones
//   cmp_val  - compare value
//   count    - current count
//   reached  - count >= cmp_val
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] cmp_val,
  output logic [CNT_W-1:0] count,
  output logic             reached
);

  always_ff @(posedge clk) begin
    if (clear)                         count <= '0;
    else if (enable && (count != '1))  count <= count + 1'b1;
  end

  assign reached = (count >= cmp_val);

endmodule

// File: rtl/junction_phase_scheduler.sv
// junction_phase_scheduler: demand-actuated phase scheduler for a three-road
// junction. Latches vehicle requests per road and grants green round-robin,
// enforcing min/max green, fixed yellow and all-red clearance.
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   car_sense    - per-road vehicle present (bit0=A, bit1=B, bit2=C)
//   road_a/b/c   - lamps {red,yellow,green}, one-hot, registered
//   active_road  - road owning current/last green (0=A,1=B,2=C)
//   phase        - 0=ALL_RED, 1=GREEN, 2=YELLOW
// Optional (macro EMERGENCY_PREEMPT_EN):
//   emerg_req    - per-road emergency request; lowest index wins
//   emerg_active - preemption currently governs selection
module junction_phase_scheduler
  import junction_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 12,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] car_sense,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic [2:0] emerg_req,
  output logic       emerg_active,
`endif
  output logic [2:0] road_a,
  output logic [2:0] road_b,
  output logic [2:0] road_c,
  output logic [1:0] active_road,
  output logic [1:0] phase
);

  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  phase_e           state;
  phase_e           nxt_phase;
  logic [1:0]       nxt_road;
  logic [2:0]       pending;
  logic [2:0]       act_mask;
  logic [2:0]       clr_mask;
  logic             others;
  logic             act_sense;
  logic             advance;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] cmp_val;
  logic             t_reached;
  logic             min_reached;
  logic             pick_found;
  logic [1:0]       pick_road;
  logic [1:0]       cand;

  assign phase = state;

  // The timer restarts on every phase change (and on reset)
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .clear   (rst | advance),
    .enable  (1'b1),
    .cmp_val (cmp_val),
    .count   (timer),
    .reached (t_reached)
  );

  always_comb begin
    case (state)
      PH_GREEN:  cmp_val = GMAX_LAST;
      PH_YELLOW: cmp_val = YEL_LAST;
      default:   cmp_val = ALLRED_LAST;
    endcase
  end

  assign min_reached = (timer >= GMIN_LAST);
  assign act_mask    = 3'b001 << active_road;
  assign others      = |(pending & ~act_mask);
  assign act_sense   = |(car_sense & act_mask);

  // Round-robin search starting after the current road; third step wraps
  // back onto the current road itself.
  always_comb begin
    pick_found = 1'b0;
    pick_road  = active_road;
    cand       = active_road;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = road_inc(cand);
      if (!pick_found && pending[cand]) begin
        pick_found = 1'b1;
        pick_road  = cand;
      end
    end
  end

`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg_any;
  logic [1:0] emerg_tgt;
  assign emerg_any = |emerg_req;
  assign emerg_tgt = emerg_req[0] ? ROAD_A : (emerg_req[1] ? ROAD_B : ROAD_C);
`endif

  always_comb begin
    nxt_phase = state;
    nxt_road  = active_road;
    case (state)
      PH_ALL_RED: begin
        if (t_reached) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (emerg_any) begin
            nxt_phase = PH_GREEN;
            nxt_road  = emerg_tgt;
          end else
`endif
          if (pick_found) begin
            nxt_phase = PH_GREEN;
            nxt_road  = pick_road;
          end
        end
      end
      PH_GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
        // Preemption overrides min green; a held target ignores max-out
        if (emerg_any) begin
          if (emerg_tgt != active_road) nxt_phase = PH_YELLOW;
        end else
`endif
        if (others && (t_reached || (min_reached && !act_sense)))
          nxt_phase = PH_YELLOW;
      end
      PH_YELLOW: begin
        if (t_reached) nxt_phase = PH_ALL_RED;
      end
      default: nxt_phase = PH_ALL_RED;
    endcase
    advance  = (nxt_phase != state);
    clr_mask = (state != PH_GREEN && nxt_phase == PH_GREEN) ? (3'b001 << nxt_road) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PH_ALL_RED;
      active_road <= ROAD_C;
      pending     <= '0;
      road_a      <= LAMP_RED;
      road_b      <= LAMP_RED;
      road_c      <= LAMP_RED;
`ifdef EMERGENCY_PREEMPT_EN
      emerg_active <= 1'b0;
`endif
    end else begin
      state       <= nxt_phase;
      active_road <= nxt_road;
      // Clear wins over a same-cycle set; the sensor re-latches next cycle
      pending     <= (pending | car_sense) & ~clr_mask;
      road_a      <= lamp_of(nxt_phase, nxt_road, ROAD_A);
      road_b      <= lamp_of(nxt_phase, nxt_road, ROAD_B);
      road_c      <= lamp_of(nxt_phase, nxt_road, ROAD_C);
`ifdef EMERGENCY_PREEMPT_EN
      emerg_active <= emerg_any;
`endif
    end
  end

endmodule

// File: tb/tb_junction_phase_scheduler.sv
module tb_junction_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] car_sense = 3'b000;
  logic [2:0] road_a, road_b, road_c;
  logic [1:0] active_road, phase;
`ifdef EMERGENCY_PREEMPT_EN
  logic [2:0] emerg_req = 3'b000;
  logic       emerg_active;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  junction_phase_scheduler #(
    .GREEN_MIN(4), .GREEN_MAX(12), .YELLOW_T(3), .ALLRED_T(2), .CNT_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .car_sense   (car_sense),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req   (emerg_req),
    .emerg_active(emerg_active),
`endif
    .road_a      (road_a),
    .road_b      (road_b),
    .road_c      (road_c),
    .active_road (active_road),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] get_lamp(input int r);
    if (r == 0) return road_a;
    if (r == 1) return road_b;
    return road_c;
  endfunction

  function automatic int count_nonred();
    return int'(road_a != 3'b100) + int'(road_b != 3'b100) + int'(road_c != 3'b100);
  endfunction

  // Count cycles the given road shows 'lamp', bounded
  task automatic run_len(input int r, input logic [2:0] lamp, output int n);
    n = 0;
    while (get_lamp(r) == lamp && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic run_allred(output int n);
    n = 0;
    while (phase == 2'd0 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_green(input int r, output int n);
    n = 0;
    while (get_lamp(r) != 3'b001 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    car_sense = 3'b000;
    repeat (3) step();
    n_cmp++;
    if ({road_a, road_b, road_c} !== 9'b100_100_100) begin
      n_bad++;
      $display("FAIL reset_lamps: got %b required %b", {road_a, road_b, road_c}, 9'b100_100_100);
    end
    n_cmp++;
    if (phase !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_phase: got %0d required 0", phase);
    end
    n_cmp++;
    if (active_road !== 2'd2) begin
      n_bad++;
      $display("FAIL reset_active: got %0d required 2", active_road);
    end
  endtask

  task automatic test_single_road();
    car_sense = 3'b001;
    rst = 1'b0;
    step();
    n_cmp++;
    if (phase !== 2'd0 || road_a !== 3'b100) begin
      n_bad++;
      $display("FAIL single_allred: got phase %0d road_a %b required 0 100", phase, road_a);
    end
    step();
    n_cmp++;
    if (road_a !== 3'b001 || phase !== 2'd1 || active_road !== 2'd0) begin
      n_bad++;
      $display("FAIL single_green_start: got road_a %b phase %0d active %0d required 001 1 0",
               road_a, phase, active_road);
    end
    for (int i = 0; i < 50; i++) begin
      step();
      n_cmp++;
      if ({road_a, road_b, road_c} !== 9'b001_100_100) begin
        n_bad++;
        $display("FAIL single_hold cycle %0d: got %b required %b", i,
                 {road_a, road_b, road_c}, 9'b001_100_100);
      end
    end
  endtask

  task automatic test_reset_mid_green();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({road_a, road_b, road_c, phase, active_road} !== {9'b100_100_100, 2'd0, 2'd2}) begin
      n_bad++;
      $display("FAIL midreset_state: got lamps %b phase %0d active %0d required 100100100 0 2",
               {road_a, road_b, road_c}, phase, active_road);
    end
    rst = 1'b0;
    car_sense = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (phase !== 2'd0) begin
        n_bad++;
        $display("FAIL midreset_pending_clear cycle %0d: got phase %0d required 0", i, phase);
      end
    end
  endtask

  task automatic test_max_out();
    int n;
    car_sense = 3'b001;
    wait_green(0, n);
    n_cmp++;
    if (road_a !== 3'b001) begin
      n_bad++;
      $display("FAIL maxout_a_green: got %b required 001", road_a);
    end
    step();                 // green cycle 1
    car_sense = 3'b011;
    step();                 // green cycle 2
    car_sense = 3'b001;
    run_len(0, 3'b001, n);
    n_cmp++;
    if (n + 2 !== 12) begin
      n_bad++;
      $display("FAIL maxout_green_len: got %0d required 12", n + 2);
    end
    run_len(0, 3'b010, n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL maxout_yellow_len: got %0d required 3", n);
    end
    run_allred(n);
    n_cmp++;
    if (n !== 2) begin
      n_bad++;
      $display("FAIL maxout_allred_len: got %0d required 2", n);
    end
    n_cmp++;
    if (road_b !== 3'b001 || active_road !== 2'd1) begin
      n_bad++;
      $display("FAIL maxout_b_green: got road_b %b active %0d required 001 1", road_b, active_road);
    end
  endtask

  task automatic test_gap_out();
    int n;
    // B is green with its sensor low and A waiting
    run_len(1, 3'b001, n);
    n_cmp++;
    if (n !== 4) begin
      n_bad++;
      $display("FAIL gapout_b_len: got %0d required 4", n);
    end
    wait_green(0, n);
    n_cmp++;
    if (road_a !== 3'b001) begin
      n_bad++;
      $display("FAIL gapout_a_green: got %b required 001", road_a);
    end
    car_sense = 3'b011;     // green cycle 0: B requests
    step();                 // green cycle 1: A sensor drops
    car_sense = 3'b000;
    run_len(0, 3'b001, n);
    n_cmp++;
    if (n + 1 !== 4) begin
      n_bad++;
      $display("FAIL gapout_a_len: got %0d required 4", n + 1);
    end
    n_cmp++;
    if (road_a !== 3'b010) begin
      n_bad++;
      $display("FAIL gapout_a_yellow: got %b required 010", road_a);
    end
    wait_green(1, n);
    n_cmp++;
    if (road_b !== 3'b001) begin
      n_bad++;
      $display("FAIL gapout_b_next: got %b required 001", road_b);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 1, 2, 0};
    int n;
    int legal_bad;
    rst = 1'b1;
    car_sense = 3'b111;
    repeat (2) step();
    rst = 1'b0;
    legal_bad = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (phase != 2'd1 && n < 100) begin
        if (count_nonred() > 1) legal_bad++;
        step();
        n++;
      end
      n_cmp++;
      if (active_road !== 2'(exp_order[k]) || get_lamp(exp_order[k]) !== 3'b001) begin
        n_bad++;
        $display("FAIL rr_order %0d: got active %0d lamp %b required %0d 001", k,
                 active_road, get_lamp(exp_order[k]), exp_order[k]);
      end
      n = 0;
      while (phase == 2'd1 && n < 200) begin
        if (count_nonred() > 1) legal_bad++;
        step();
        n++;
      end
      n_cmp++;
      if (n !== 12) begin
        n_bad++;
        $display("FAIL rr_green_len %0d: got %0d required 12", k, n);
      end
    end
    n_cmp++;
    if (legal_bad !== 0) begin
      n_bad++;
      $display("FAIL rr_one_nonred: got %0d violating cycles required 0", legal_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_road();
    test_reset_mid_green();
    test_max_out();
    test_gap_out();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/junction_phase_scheduler.md
Name: junction_phase_scheduler

Overview:
- Demand-actuated phase scheduler for a three-road junction (roads A, B, C).
- Latches vehicle-sense requests per road and grants green to one road at a time, round-robin.
- Enforces minimum/maximum green, fixed yellow and all-red clearance intervals.
- Drives the same 3-bit per-road lamp outputs as the existing fixed-time three-way controller, so it can replace it at the junction top level.

Parameters:
- GREEN_MIN, 4: minimum green duration in cycles (>=1).
- GREEN_MAX, 12: maximum green duration in cycles while another road waits (>=GREEN_MIN).
- YELLOW_T, 3: yellow duration in cycles (>=1).
- ALLRED_T, 2: all-red clearance in cycles (>=1).
- CNT_W, 8: phase timer width; every timing parameter must fit in CNT_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- car_sense  in  3  per-road vehicle present (bit0=A, bit1=B, bit2=C).
- road_a  out  3  lamp for A: {red,yellow,green}, one-hot.
- road_b  out  3  lamp for B, same encoding.
- road_c  out  3  lamp for C, same encoding.
- active_road  out  2  index of the road owning the current/last green (0=A, 1=B, 2=C).
- phase  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW.

Interface (decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- All outputs are registered and change only on a rising clk edge.
- Lamp encoding:
  - Non-active road, and all roads in ALL_RED: 3'b100.
  - Active road in GREEN: 3'b001.
  - Active road in YELLOW: 3'b010.
  - Never more than one road is non-red.
- Reset (rst=1 at an edge, including mid-phase):
  - phase=ALL_RED, active_road=2, timer=0, pending=0.
  - All lamps 3'b100.
- pending[i]:
  - Set when car_sense[i]=1.
  - Cleared on the edge entering GREEN for road i.
  - A set and a clear in the same cycle resolve to clear; the current sensor value is re-latched on the next cycle.
- Timer: cleared on every phase entry; increments each cycle in phase; saturates at all-ones.
- ALL_RED:
  - At timer==ALLRED_T-1 or later, pick the next road with pending set, searching active_road+1, +2, +3 (mod 3). The +3 case is the current road itself.
  - If a road is found, enter GREEN for it. If none is pending, stay in ALL_RED and re-evaluate every cycle.
- GREEN, with "others" = any pending bit for a road other than active_road:
  - If others=0, hold green indefinitely.
  - If others=1 and timer>=GREEN_MAX-1, enter YELLOW (max-out).
  - If others=1, timer>=GREEN_MIN-1 and car_sense[active]=0, enter YELLOW (gap-out).
  - Resulting green length is between GREEN_MIN and GREEN_MAX cycles whenever others is asserted.
- YELLOW: exactly YELLOW_T cycles, then ALL_RED.
- Round-robin fairness: with all roads continuously requesting, greens rotate A→B→C→A.
- Illegal state encoding: next cycle goes to ALL_RED.

Optional Feature:
- Macro: EMERGENCY_PREEMPT_EN.
- When defined:
  - Adds input port emerg_req [2:0].
  - Target road = lowest index with emerg_req set.
  - If the target differs from the active green road, GREEN goes to YELLOW on the next edge, ignoring GREEN_MIN.
  - ALL_RED then selects the target, overriding round-robin.
  - The target's green holds while emerg_req[target]=1; normal rules resume when it drops.
  - YELLOW and ALL_RED durations are never shortened.
  - Output emerg_active (1 bit) is high while preemption governs selection.
- When undefined: neither port exists; behaviour is exactly as above.

Decomposition:
- Package junction_pkg holds:
  - Phase enum PH_ALL_RED, PH_GREEN, PH_YELLOW.
  - Lamp constants LAMP_RED=3'b100, LAMP_YELLOW=3'b010, LAMP_GREEN=3'b001.
  - Road index constants ROAD_A, ROAD_B, ROAD_C.
- One sub-module, phase_timer: clear, enable, saturating CNT_W counter with a compare-to-value `reached` output.
- Round-robin pick stays inline as combinational logic.

Test Plan (default parameters):
- Reset held 3 cycles mid-GREEN → next cycle all lamps 3'b100, phase=0, active_road=2, pending cleared.
- car_sense=3'b001 from reset release → ALL_RED for 2 cycles, then road_a=3'b001; A holds green 50+ cycles while B and C stay idle.
- A green, car_sense[1] pulsed 1 cycle at green cycle 1, A sensor kept high → A green exactly 12 cycles, yellow 3, all-red 2, then road_b=3'b001.
- A green, B pending, A sensor dropped at green cycle 1 → gap-out, A green exactly 4 cycles, then yellow.
- car_sense=3'b111 constant → green order A, B, C, A, each green 12 cycles; lamps never show two non-red roads.
- EMERGENCY_PREEMPT_EN defined, A green at cycle 1, emerg_req=3'b100 → road_a yellow next edge, C green after 3+2 cycles, C held while the request stays asserted, emerg_active=1.
